uart_burst_tx: RTL and testbench

// - UART transmitter that accepts a DEPTH-byte word in one valid/ready handshake.
// - Serialises the bytes back-to-back as 8N1 frames on tx.
// - Sits between a packed-byte producer (e.g. FFT result packer) and the board UART pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_burst_tx.sv | 123 ++++++++++++
 tb/tb_uart_burst_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the burst UART transmitter.
package uart_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 115_200;
   localparam int BYTE_W       = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Rounded-to-nearest clock cycles per serial bit.
   function automatic int clks_per_bit(input int freq, input int baud);
      return (freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses bit_done_o on the last one.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic arst,
   input  logic clear_i,
   output logic bit_done_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_done_o = !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || bit_done_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_burst_tx.sv
// Accepts DEPTH bytes in one handshake and sends them back-to-back as 8N1 frames,
// byte 0 first. arst is expected to be released synchronously to clk by its source.
module uart_burst_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int boadrate = DEF_BAUD,
   parameter int DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic [DEPTH-1:0][BYTE_W-1:0] data_i,
   input  logic                         up_valid,
   output logic                         up_ready,
   output logic                         tx
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, boadrate);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST_BYTE = IW'(DEPTH - 1);

   state_t                       state_q, state_d;
   logic [DEPTH-1:0][BYTE_W-1:0] buf_q, buf_d;
   logic [BYTE_W-1:0]            shift_q, shift_d;
   logic [2:0]                   bit_idx_q, bit_idx_d;
   logic [IW-1:0]                byte_idx_q, byte_idx_d;
   logic [IW-1:0]                byte_nxt;
   logic                         tx_q, tx_d;
   logic                         baud_clr;
   logic                         bit_done;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .arst      (arst),
      .clear_i   (baud_clr),
      .bit_done_o(bit_done)
   );

   assign up_ready = (state_q == IDLE);
   assign tx       = tx_q;
   assign byte_nxt = byte_idx_q + IW'(1);

   // tx_d is the line level for the cycle after each edge, so every bit
   // change is decided at the same edge as the state change that causes it.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      tx_d       = tx_q;
      baud_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            baud_clr = 1'b1;
            tx_d     = 1'b1;
            if (up_valid) begin
               buf_d      = data_i;
               shift_d    = data_i[0];
               bit_idx_d  = '0;
               byte_idx_d = '0;
               tx_d       = 1'b0;
               state_d    = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = IDLE;
               end else begin
                  byte_idx_d = byte_nxt;
                  shift_d    = buf_q[byte_nxt];
                  bit_idx_d  = '0;
                  tx_d       = 1'b0;
                  state_d    = START;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_burst_tx.sv
// Randomised bench for uart_burst_tx against an 8N1 bit-stream model; short bit period keeps runs small.
module tb_uart_burst_tx;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 3_000_000;
   localparam int DEPTH    = 8;
   localparam int CPB      = 17;          // 50e6/3e6 = 16.67, rounded to nearest
   localparam int NBITS    = DEPTH * 10;

   logic                  clk = 1'b0;
   logic                  arst;
   logic [DEPTH-1:0][7:0] data_i;
   logic                  up_valid;
   logic                  up_ready;
   logic                  tx;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   always #10 clk = ~clk;

   uart_burst_tx #(
      .CLK_FREQ(CLK_FREQ),
      .boadrate(BAUD),
      .DEPTH   (DEPTH)
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .data_i  (data_i),
      .up_valid(up_valid),
      .up_ready(up_ready),
      .tx      (tx)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line levels of a whole burst: per byte a 0 start bit, 8 data bits LSB first, a 1 stop bit.
   function automatic logic [NBITS-1:0] frame_bits(input logic [DEPTH*8-1:0] word);
      logic [NBITS-1:0] s;
      s = '0;
      for (int b = 0; b < DEPTH; b++) begin
         s[b*10] = 1'b0;
         for (int i = 0; i < 8; i++) begin
            s[b*10+1+i] = word[b*8+i];
         end
         s[b*10+9] = 1'b1;
      end
      return s;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      up_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick;
         check("idle_tx", 64'(tx), 64'd1);
         check("idle_ready", 64'(up_ready), 64'd1);
      end
   endtask

   // Hand over one word, then sample every bit at mid-period. With noise set, inputs are
   // scrambled while busy; with chain set, next_word is presented and held for the tail.
   task automatic send_word(input logic [63:0] word, input bit noise, input bit chain,
                            input logic [63:0] next_word);
      logic [NBITS-1:0] exp;
      int               cyc;
      int               err0;
      err0 = errors;
      exp  = frame_bits(word);
      check("ready_before", 64'(up_ready), 64'd1);
      data_i   = word;
      up_valid = 1'b1;
      tick;
      up_valid = 1'b0;
      cyc      = 0;
      while (up_ready === 1'b0 && cyc < NBITS * CPB + 8) begin
         if (cyc == 0) check("start_lat", 64'(tx), 64'd0);
         if (cyc % CPB == CPB / 2) check($sformatf("bit%0d", cyc / CPB), 64'(tx), 64'(exp[cyc/CPB]));
         if (noise && cyc < (NBITS - 10) * CPB) begin
            up_valid = 1'($urandom_range(0, 1));
            data_i   = {$urandom, $urandom};
         end else begin
            up_valid = chain;
            if (chain) data_i = next_word;
         end
         tick;
         cyc++;
      end
      check("burst_len", 64'(cyc), 64'(NBITS * CPB));
      check("ready_end", 64'(up_ready), 64'd1);
      check("tx_end", 64'(tx), 64'd1);
      txn++;
      $display("txn %0d word %016h cycles %0d noise %0d chain %0d new_errors %0d",
               txn, word, cyc, noise, chain, errors - err0);
   endtask

   initial begin
      logic [63:0] w, nw;
      bit          ch;
      int          low_cnt, nrdy_cnt;
      data_i   = '0;
      up_valid = 1'b0;
      arst     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rst_tx", 64'(tx), 64'd1);
         check("rst_ready", 64'(up_ready), 64'd1);
      end
      arst = 1'b0;
      idle(4);

      // Reference word, then a back-to-back second word held valid across the boundary.
      send_word({32'h01020304, 32'h10203040}, 1'b0, 1'b1, 64'h11121314);
      send_word(64'h11121314, 1'b0, 1'b0, 64'h0);
      idle(5);

      // Inputs scrambled while busy must not disturb the word in flight.
      send_word(64'h0123456789abcdef, 1'b1, 1'b0, 64'h0);
      idle(3);

      for (int n = 0; n < 6; n++) begin
         w  = {$urandom, $urandom};
         nw = {$urandom, $urandom};
         ch = 1'($urandom_range(0, 1));
         send_word(w, 1'b1, ch, nw);
         if (ch) send_word(nw, 1'b0, 1'b0, 64'h0);
         idle(2);
      end

      // All-zero word keeps tx low during data bits, so the async reset effect is visible.
      data_i   = '0;
      up_valid = 1'b1;
      tick;
      up_valid = 1'b0;
      for (int i = 0; i < 3 * CPB + CPB / 2; i++) tick;
      check("mid_tx_low", 64'(tx), 64'd0);
      #3 arst = 1'b1;
      #1;
      check("rst_async_tx", 64'(tx), 64'd1);
      check("rst_async_ready", 64'(up_ready), 64'd1);
      tick;
      tick;
      arst     = 1'b0;
      low_cnt  = 0;
      nrdy_cnt = 0;
      for (int i = 0; i < 30 * CPB; i++) begin
         tick;
         if (tx !== 1'b1) low_cnt++;
         if (up_ready !== 1'b1) nrdy_cnt++;
      end
      check("no_frames_after_rst", 64'(low_cnt), 64'd0);
      check("ready_after_rst", 64'(nrdy_cnt), 64'd0);
      txn++;
      $display("txn %0d reset mid-burst low_cycles %0d not_ready_cycles %0d", txn, low_cnt, nrdy_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
